// File: rtl/cv32e41p_pkg.sv
// Shared ALU package: types and constants for the serial multiplier.
package cv32e41p_pkg;

    // Number of radix-2 iterations the serial multiplier runs for a full-width operand
    localparam int MUL_SERIAL_CYCLES = 32;

    // Serial multiplier control states
    typedef enum logic [1:0] {
        MS_IDLE     = 2'd0,
        MS_MULTIPLY = 2'd1,
        MS_FINISH   = 2'd2
    } mul_serial_state_e;

endpackage

// File: rtl/cv32e41p_alu_mul_lzc.sv
// Combinational leading-zero counter; returns C_WIDTH for an all-zero input.
module cv32e41p_alu_mul_lzc #(
    parameter int C_WIDTH     = 32,
    parameter int C_LOG_WIDTH = 6
) (
    input  logic [C_WIDTH-1:0]     i_data,
    output logic [C_LOG_WIDTH-1:0] o_count
);

    // Scan LSB to MSB so the highest set bit determines the final count
    always_comb begin
        o_count = C_LOG_WIDTH'(C_WIDTH);
        for (int i = 0; i < C_WIDTH; i++) begin
            if (i_data[i]) begin
                o_count = C_LOG_WIDTH'(C_WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/cv32e41p_alu_mul_serial.sv
// Radix-2 shift-and-add serial multiplier (MUL/MULH/MULHSU/MULHU).
// Operands are reduced to sign-magnitude, the unsigned product is accumulated
// MSB-first over the multiplier bits and the sign is re-applied at the output.
// Optional early termination on leading zeros of the multiplier magnitude:
// define CV32E41P_MUL_EARLY_TERM_EN.
module cv32e41p_alu_mul_serial
    import cv32e41p_pkg::*;
#(
    parameter int C_WIDTH     = MUL_SERIAL_CYCLES,
    parameter int C_LOG_WIDTH = 6
) (
    input  logic               Clk_CI,
    input  logic               Rst_RI,
    input  logic [C_WIDTH-1:0] OpA_DI,
    input  logic [C_WIDTH-1:0] OpB_DI,
    input  logic               OpASign_SI,
    input  logic               OpBSign_SI,
    input  logic               OpHigh_SI,
    input  logic               InVld_SI,
    output logic               InRdy_SO,
    input  logic               OutRdy_SI,
    output logic               OutVld_SO,
    output logic [C_WIDTH-1:0] Res_DO
);

    mul_serial_state_e      r_state, w_state_next;
    logic [C_WIDTH-1:0]     r_mag_a, w_mag_a_next;
    logic [C_WIDTH-1:0]     r_mag_b, w_mag_b_next;
    logic [2*C_WIDTH-1:0]   r_acc, w_acc_next;
    logic [C_LOG_WIDTH-1:0] r_cnt, w_cnt_next;
    logic                   r_res_inv, w_res_inv_next;
    logic                   r_high_sel, w_high_sel_next;

    logic                   w_a_neg, w_b_neg;
    logic [C_WIDTH-1:0]     w_mag_a_in, w_mag_b_in;
    logic [C_WIDTH-1:0]     w_mag_b_load;
    logic [C_LOG_WIDTH-1:0] w_cnt_load;
    logic                   w_skip;
    logic [2*C_WIDTH-1:0]   w_addend, w_acc_step, w_product;

    // Operand magnitudes; the most negative value maps to 2^(W-1), which fits unsigned
    assign w_a_neg    = OpASign_SI & OpA_DI[C_WIDTH-1];
    assign w_b_neg    = OpBSign_SI & OpB_DI[C_WIDTH-1];
    assign w_mag_a_in = w_a_neg ? (-OpA_DI) : OpA_DI;
    assign w_mag_b_in = w_b_neg ? (-OpB_DI) : OpB_DI;

`ifdef CV32E41P_MUL_EARLY_TERM_EN
    logic [C_LOG_WIDTH-1:0] w_lz;

    cv32e41p_alu_mul_lzc #(
        .C_WIDTH     (C_WIDTH),
        .C_LOG_WIDTH (C_LOG_WIDTH)
    ) u_lzc (
        .i_data  (w_mag_b_in),
        .o_count (w_lz)
    );

    // Leading zeros contribute nothing to the product, so skip their iterations
    assign w_mag_b_load = w_mag_b_in << w_lz;
    assign w_cnt_load   = C_LOG_WIDTH'(C_WIDTH) - w_lz;
    assign w_skip       = (w_lz == C_LOG_WIDTH'(C_WIDTH));
`else
    assign w_mag_b_load = w_mag_b_in;
    assign w_cnt_load   = C_LOG_WIDTH'(C_WIDTH);
    assign w_skip       = 1'b0;
`endif

    // One MSB-first shift-and-add step and the sign-corrected result
    assign w_addend   = r_mag_b[C_WIDTH-1] ? {{C_WIDTH{1'b0}}, r_mag_a} : '0;
    assign w_acc_step = (r_acc << 1) + w_addend;
    assign w_product  = r_res_inv ? (-r_acc) : r_acc;
    assign Res_DO     = r_high_sel ? w_product[2*C_WIDTH-1:C_WIDTH] : w_product[C_WIDTH-1:0];

    // State and datapath registers
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            r_state    <= MS_IDLE;
            r_mag_a    <= '0;
            r_mag_b    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_res_inv  <= 1'b0;
            r_high_sel <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_mag_a    <= w_mag_a_next;
            r_mag_b    <= w_mag_b_next;
            r_acc      <= w_acc_next;
            r_cnt      <= w_cnt_next;
            r_res_inv  <= w_res_inv_next;
            r_high_sel <= w_high_sel_next;
        end
    end

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        w_state_next    = r_state;
        w_mag_a_next    = r_mag_a;
        w_mag_b_next    = r_mag_b;
        w_acc_next      = r_acc;
        w_cnt_next      = r_cnt;
        w_res_inv_next  = r_res_inv;
        w_high_sel_next = r_high_sel;
        InRdy_SO        = 1'b0;
        OutVld_SO       = 1'b0;

        case (r_state)
            MS_IDLE: begin
                InRdy_SO = 1'b1;
                if (InVld_SI) begin
                    w_mag_a_next    = w_mag_a_in;
                    w_mag_b_next    = w_mag_b_load;
                    w_acc_next      = '0;
                    w_cnt_next      = w_cnt_load;
                    w_res_inv_next  = w_a_neg ^ w_b_neg;
                    w_high_sel_next = OpHigh_SI;
                    w_state_next    = w_skip ? MS_FINISH : MS_MULTIPLY;
                end
            end
            MS_MULTIPLY: begin
                w_acc_next   = w_acc_step;
                w_mag_b_next = r_mag_b << 1;
                w_cnt_next   = r_cnt - C_LOG_WIDTH'(1);
                if (r_cnt == C_LOG_WIDTH'(1)) begin
                    w_state_next = MS_FINISH;
                end
            end
            MS_FINISH: begin
                OutVld_SO = 1'b1;
                if (OutRdy_SI) begin
                    w_state_next = MS_IDLE;
                end
            end
            default: begin
                w_state_next = MS_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cv32e41p_alu_mul_serial.sv
// Randomized self-checking bench for the serial multiplier.
module tb_cv32e41p_alu_mul_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op_a, op_b;
    logic        sign_a, sign_b, high;
    logic        in_vld, in_rdy, out_rdy, out_vld;
    logic [31:0] res;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cv32e41p_alu_mul_serial dut (
        .Clk_CI     (clk),
        .Rst_RI     (rst),
        .OpA_DI     (op_a),
        .OpB_DI     (op_b),
        .OpASign_SI (sign_a),
        .OpBSign_SI (sign_b),
        .OpHigh_SI  (high),
        .InVld_SI   (in_vld),
        .InRdy_SO   (in_rdy),
        .OutRdy_SI  (out_rdy),
        .OutVld_SO  (out_vld),
        .Res_DO     (res)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RISC-V M reference: extend each operand per its sign flag, multiply modulo 2^64
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb, input logic hi);
        logic [63:0] ea, eb, p;
        ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return hi ? p[63:32] : p[31:0];
    endfunction

    // Accept-to-valid latency in cycles
    function automatic int exp_lat(input logic [31:0] b, input logic sb);
`ifdef CV32E41P_MUL_EARLY_TERM_EN
        logic [31:0] mag;
        int top;
        mag = (sb && b[31]) ? (32'd0 - b) : b;
        if (mag == 32'd0) return 1;
        top = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) top = i;
        return top + 2;
`else
        return 33;
`endif
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'h0000_FFFF & $urandom;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input logic hi,
                          input logic [31:0] exp_res, input int bp);
        int lat;
        logic [31:0] held;
        @(negedge clk);
        check({tag, "/in_rdy_idle"}, in_rdy, 1);
        op_a = a; op_b = b; sign_a = sa; sign_b = sb; high = hi;
        in_vld = 1'b1; out_rdy = 1'b0;
        @(posedge clk); #1;
        // Operands may change freely after the accept edge; stray valids must be ignored
        in_vld = 1'b0;
        op_a = $urandom; op_b = $urandom;
        sign_a = 1'($urandom); sign_b = 1'($urandom); high = 1'($urandom);
        lat = 1;
        while (out_vld !== 1'b1 && lat < 200) begin
            in_vld = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_vld = 1'b0;
        check({tag, "/latency"}, lat, exp_lat(b, sb));
        check({tag, "/result"}, res, exp_res);
        held = res;
        for (int i = 0; i < bp; i++) begin
            in_vld = 1'($urandom);
            op_a = $urandom; op_b = $urandom;
            @(posedge clk); #1;
            check({tag, "/bp_vld"}, out_vld, 1);
            check({tag, "/bp_in_rdy"}, in_rdy, 0);
            check({tag, "/bp_hold"}, res, held);
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
        check({tag, "/done_vld"}, out_vld, 0);
        check({tag, "/done_in_rdy"}, in_rdy, 1);
        $display("op %s a=%h b=%h sa=%0d sb=%0d hi=%0d res=%h exp=%h lat=%0d",
                 tag, a, b, sa, sb, hi, held, exp_res, lat);
    endtask

    initial begin
        logic [31:0] a, b;
        logic sa, sb, hi;
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
        op_a = '0; op_b = '0; sign_a = 1'b0; sign_b = 1'b0; high = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/in_rdy", in_rdy, 1);
        check("reset/out_vld", out_vld, 0);
        check("reset/res", res, 0);
        rst = 1'b0;

        // Directed corner cases with hand-derived results
        run_op("mulhu_ff",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 32'hFFFF_FFFE, 5);
        run_op("mul_ff",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 32'h0000_0001, 0);
        run_op("mulh_minmin", 32'h8000_0000, 32'h8000_0000, 1, 1, 1, 32'h4000_0000, 1);
        run_op("mul_m1x3",    32'hFFFF_FFFF, 32'h0000_0003, 1, 1, 0, 32'hFFFF_FFFD, 0);
        run_op("mulh_m1x3",   32'hFFFF_FFFF, 32'h0000_0003, 1, 1, 1, 32'hFFFF_FFFF, 2);
        run_op("mulhsu_hi",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1, 32'hFFFF_FFFF, 0);
        run_op("mulhsu_lo",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 32'h0000_0001, 0);
        run_op("b_zero",      32'h0000_1234, 32'h0000_0000, 1, 1, 0, 32'h0000_0000, 0);
        run_op("b_one",       32'h0000_1234, 32'h0000_0001, 0, 0, 0, 32'h0000_1234, 0);
        run_op("b_msb_hi",    32'h0000_0005, 32'h8000_0000, 0, 0, 1, 32'h0000_0002, 0);
        run_op("min_x_m1",    32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 1, 32'h0000_0000, 0);
        run_op("neg_zero",    32'h0000_0000, 32'h8000_0000, 1, 1, 1, 32'h0000_0000, 0);

        // Reset in the middle of a long operation abandons it
        @(negedge clk);
        op_a = 32'd5; op_b = 32'hFFFF_FFFF; sign_a = 1'b0; sign_b = 1'b0; high = 1'b0;
        in_vld = 1'b1;
        @(posedge clk); #1;
        in_vld = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst/out_vld", out_vld, 0);
        check("midrst/res", res, 0);
        check("midrst/in_rdy", in_rdy, 1);
        run_op("after_rst", 32'd7, 32'd6, 0, 0, 0, 32'd42, 0);

        // Randomized operations against the reference model
        for (int n = 0; n < 60; n++) begin
            a  = rnd_operand();
            b  = rnd_operand();
            sa = 1'($urandom);
            sb = 1'($urandom);
            hi = 1'($urandom);
            run_op($sformatf("rnd%0d", n), a, b, sa, sb, hi, ref_mul(a, b, sa, sb, hi),
                   $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
